// File: rtl/id_ex_ctrl_seg.sv
// id_ex_ctrl_seg: ID->EX pipeline register with stall/flush, valid gating of control fields,
// and saturating bubble/stall counters for debug.
module id_ex_ctrl_seg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clear,
    input  logic            valid_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    input  logic [4:0]      rd_d,
    input  logic [XLEN-1:0] reg1_d,
    input  logic [XLEN-1:0] reg2_d,
    input  logic [XLEN-1:0] imm_d,
    input  logic            jalr_d,
    input  logic            mem_to_reg_d,
    input  logic            load_npc_d,
    input  logic [2:0]      reg_write_d,
    input  logic [3:0]      mem_write_d,
    input  logic [1:0]      reg_read_d,
    input  logic [2:0]      branch_type_d,
    input  logic [3:0]      alu_ctrl_d,
    input  logic            alu_src1_d,
    input  logic [1:0]      alu_src2_d,
    output logic            valid_e,
    output logic [XLEN-1:0] pc_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e,
    output logic [XLEN-1:0] reg1_e,
    output logic [XLEN-1:0] reg2_e,
    output logic [XLEN-1:0] imm_e,
    output logic            jalr_e,
    output logic            mem_to_reg_e,
    output logic            load_npc_e,
    output logic [2:0]      reg_write_e,
    output logic [3:0]      mem_write_e,
    output logic [1:0]      reg_read_e,
    output logic [2:0]      branch_type_e,
    output logic [3:0]      alu_ctrl_e,
    output logic            alu_src1_e,
    output logic [1:0]      alu_src2_e,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    logic bubble, hold, capture;
    logic bubble_max, stall_max;

    assign bubble     = clear;
    assign hold       = !clear && !en;
    assign capture    = !clear && en;
    assign bubble_max = &bubble_cnt;
    assign stall_max  = &stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            valid_e       <= 1'b0;
            pc_e          <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
            reg1_e        <= '0;
            reg2_e        <= '0;
            imm_e         <= '0;
            jalr_e        <= 1'b0;
            mem_to_reg_e  <= 1'b0;
            load_npc_e    <= 1'b0;
            reg_write_e   <= '0;
            mem_write_e   <= '0;
            reg_read_e    <= '0;
            branch_type_e <= '0;
            alu_ctrl_e    <= '0;
            alu_src1_e    <= 1'b0;
            alu_src2_e    <= '0;
        end else if (capture) begin
            // Data fields pass through; control collapses to NOP for a non-valid slot.
            valid_e       <= valid_d;
            pc_e          <= pc_d;
            rs1_e         <= rs1_d;
            rs2_e         <= rs2_d;
            rd_e          <= rd_d;
            reg1_e        <= reg1_d;
            reg2_e        <= reg2_d;
            imm_e         <= imm_d;
            jalr_e        <= valid_d & jalr_d;
            mem_to_reg_e  <= valid_d & mem_to_reg_d;
            load_npc_e    <= valid_d & load_npc_d;
            reg_write_e   <= valid_d ? reg_write_d : '0;
            mem_write_e   <= valid_d ? mem_write_d : '0;
            reg_read_e    <= valid_d ? reg_read_d : '0;
            branch_type_e <= valid_d ? branch_type_d : '0;
            alu_ctrl_e    <= valid_d ? alu_ctrl_d : '0;
            alu_src1_e    <= valid_d & alu_src1_d;
            alu_src2_e    <= valid_d ? alu_src2_d : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (bubble && !bubble_max)
                bubble_cnt <= bubble_cnt + 1'b1;
            if (hold && valid_e && !stall_max)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_ex_ctrl_seg.sv
// tb_id_ex_ctrl_seg: directed bench for id_ex_ctrl_seg with immediate-assertion checks.
module tb_id_ex_ctrl_seg;
    logic        clk = 1'b0;
    logic        rst, en, clear, valid_d;
    logic [31:0] pc_d, reg1_d, reg2_d, imm_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        jalr_d, mem_to_reg_d, load_npc_d, alu_src1_d;
    logic [2:0]  reg_write_d, branch_type_d;
    logic [3:0]  mem_write_d, alu_ctrl_d;
    logic [1:0]  reg_read_d, alu_src2_d;
    logic        valid_e;
    logic [31:0] pc_e, reg1_e, reg2_e, imm_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        jalr_e, mem_to_reg_e, load_npc_e, alu_src1_e;
    logic [2:0]  reg_write_e, branch_type_e;
    logic [3:0]  mem_write_e, alu_ctrl_e;
    logic [1:0]  reg_read_e, alu_src2_e;
    logic [3:0]  bubble_cnt, stall_cnt;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    id_ex_ctrl_seg #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .valid_d(valid_d),
        .pc_d(pc_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .reg1_d(reg1_d), .reg2_d(reg2_d), .imm_d(imm_d),
        .jalr_d(jalr_d), .mem_to_reg_d(mem_to_reg_d), .load_npc_d(load_npc_d),
        .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .reg_read_d(reg_read_d),
        .branch_type_d(branch_type_d), .alu_ctrl_d(alu_ctrl_d),
        .alu_src1_d(alu_src1_d), .alu_src2_d(alu_src2_d),
        .valid_e(valid_e), .pc_e(pc_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .reg1_e(reg1_e), .reg2_e(reg2_e), .imm_e(imm_e),
        .jalr_e(jalr_e), .mem_to_reg_e(mem_to_reg_e), .load_npc_e(load_npc_e),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .reg_read_e(reg_read_e),
        .branch_type_e(branch_type_e), .alu_ctrl_e(alu_ctrl_e),
        .alu_src1_e(alu_src1_e), .alu_src2_e(alu_src2_e),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl_zero(input string tag);
        chk({tag, " valid_e"}, 32'(valid_e), 0);
        chk({tag, " jalr_e"}, 32'(jalr_e), 0);
        chk({tag, " mem_to_reg_e"}, 32'(mem_to_reg_e), 0);
        chk({tag, " load_npc_e"}, 32'(load_npc_e), 0);
        chk({tag, " reg_write_e"}, 32'(reg_write_e), 0);
        chk({tag, " mem_write_e"}, 32'(mem_write_e), 0);
        chk({tag, " reg_read_e"}, 32'(reg_read_e), 0);
        chk({tag, " branch_type_e"}, 32'(branch_type_e), 0);
        chk({tag, " alu_ctrl_e"}, 32'(alu_ctrl_e), 0);
        chk({tag, " alu_src1_e"}, 32'(alu_src1_e), 0);
        chk({tag, " alu_src2_e"}, 32'(alu_src2_e), 0);
    endtask

    initial begin
        // Reset with every input non-zero
        rst = 1; en = 1; clear = 0; valid_d = 1;
        pc_d = 32'hDEAD_BEEF; rs1_d = 5'd7; rs2_d = 5'd9; rd_d = 5'd11;
        reg1_d = 32'h1111_1111; reg2_d = 32'h2222_2222; imm_d = 32'h3333_3333;
        jalr_d = 1; mem_to_reg_d = 1; load_npc_d = 1; reg_write_d = 3'b111;
        mem_write_d = 4'hF; reg_read_d = 2'b11; branch_type_d = 3'b101;
        alu_ctrl_d = 4'hA; alu_src1_d = 1; alu_src2_d = 2'b10;
        step(2);
        chk_ctrl_zero("reset");
        chk("reset pc_e", pc_e, 0);
        chk("reset rs1_e", 32'(rs1_e), 0);
        chk("reset rs2_e", 32'(rs2_e), 0);
        chk("reset rd_e", 32'(rd_e), 0);
        chk("reset reg1_e", reg1_e, 0);
        chk("reset reg2_e", reg2_e, 0);
        chk("reset imm_e", imm_e, 0);
        chk("reset bubble_cnt", 32'(bubble_cnt), 0);
        chk("reset stall_cnt", 32'(stall_cnt), 0);

        // Capture
        rst = 0; pc_d = 32'h40; alu_ctrl_d = 4'd3; reg_write_d = 3'b011;
        mem_write_d = 4'b1111; rd_d = 5'd5; branch_type_d = 3'b000; jalr_d = 0;
        step(1);
        chk("cap pc_e", pc_e, 32'h40);
        chk("cap alu_ctrl_e", 32'(alu_ctrl_e), 3);
        chk("cap reg_write_e", 32'(reg_write_e), 3);
        chk("cap mem_write_e", 32'(mem_write_e), 4'hF);
        chk("cap rd_e", 32'(rd_e), 5);
        chk("cap valid_e", 32'(valid_e), 1);
        chk("cap rs1_e", 32'(rs1_e), 7);
        chk("cap reg2_e", reg2_e, 32'h2222_2222);
        chk("cap imm_e", imm_e, 32'h3333_3333);
        chk("cap alu_src2_e", 32'(alu_src2_e), 2);
        chk("cap load_npc_e", 32'(load_npc_e), 1);

        // Stall for three cycles while inputs move on
        en = 0; pc_d = 32'h44; branch_type_d = 3'b001;
        step(1);
        chk("stall1 pc_e", pc_e, 32'h40);
        chk("stall1 stall_cnt", 32'(stall_cnt), 1);
        step(2);
        chk("stall3 pc_e", pc_e, 32'h40);
        chk("stall3 branch_type_e", 32'(branch_type_e), 0);
        chk("stall3 stall_cnt", 32'(stall_cnt), 3);
        chk("stall3 bubble_cnt", 32'(bubble_cnt), 0);
        en = 1;
        step(1);
        chk("resume pc_e", pc_e, 32'h44);
        chk("resume branch_type_e", 32'(branch_type_e), 1);
        chk("resume stall_cnt", 32'(stall_cnt), 3);

        // Flush beats stall
        clear = 1; en = 0;
        step(1);
        chk_ctrl_zero("flush");
        chk("flush pc_e", pc_e, 0);
        chk("flush rd_e", 32'(rd_e), 0);
        chk("flush bubble_cnt", 32'(bubble_cnt), 1);
        chk("flush stall_cnt", 32'(stall_cnt), 3);

        // Hold of an empty slot does not count as a stall
        clear = 0; en = 0;
        step(1);
        chk("hold-empty stall_cnt", 32'(stall_cnt), 3);

        // Invalid slot: control zeroed, data captured
        en = 1; valid_d = 0; reg_write_d = 3'b011; mem_write_d = 4'b0001; pc_d = 32'h80;
        jalr_d = 1; imm_d = 32'h0000_0ABC;
        step(1);
        chk_ctrl_zero("invalid");
        chk("invalid pc_e", pc_e, 32'h80);
        chk("invalid imm_e", imm_e, 32'h0000_0ABC);
        chk("invalid rd_e", 32'(rd_e), 5);

        // Bubble counter saturation at 15
        clear = 1; valid_d = 1;
        step(13);
        chk("sat13 bubble_cnt", 32'(bubble_cnt), 14);
        step(1);
        chk("sat14 bubble_cnt", 32'(bubble_cnt), 15);
        step(6);
        chk("sat20 bubble_cnt", 32'(bubble_cnt), 15);
        chk("sat20 stall_cnt", 32'(stall_cnt), 3);

        // Reset mid-flush
        rst = 1;
        step(1);
        chk("rst-flush bubble_cnt", 32'(bubble_cnt), 0);
        chk("rst-flush stall_cnt", 32'(stall_cnt), 0);
        rst = 0; clear = 0; en = 0;
        step(1);
        chk("post-rst valid_e", 32'(valid_e), 0);
        chk("post-rst stall_cnt", 32'(stall_cnt), 0);
        chk("post-rst bubble_cnt", 32'(bubble_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
